tile_coverage_walker: RTL

Coarse-raster stage directly downstream of the tile subdivision unit. Accepts one triangle's clamped tile bounding box plus three edge equations, walks the box in raster order one tile per cycle, and rejects tiles trivially outside any edge using incrementally stepped corner evaluations. Emits surviving tile coordinates, each with a fully-covered flag, to the fine rasterizer through a ready/valid handshake.

---
 rtl/tile_coverage_walker.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tile_coverage_walker.sv
// Coarse rasterizer stage: walks a triangle's tile bounding box in raster order,
// steps three edge functions per tile and forwards tiles not trivially outside.
module tile_coverage_walker #(
  parameter int IW        = 24,
  parameter int FW        = 8,
  parameter int TILE_LOG2 = 4,
  parameter int CW        = IW + 2,
  parameter int EW        = CW + FW + TILE_LOG2 + 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          tile_x_min,
  input  logic [15:0]          tile_x_max,
  input  logic [15:0]          tile_y_min,
  input  logic [15:0]          tile_y_max,
  input  logic signed [CW-1:0] A0,
  input  logic signed [CW-1:0] B0,
  input  logic signed [CW-1:0] C0,
  input  logic signed [CW-1:0] A1,
  input  logic signed [CW-1:0] B1,
  input  logic signed [CW-1:0] C1,
  input  logic signed [CW-1:0] A2,
  input  logic signed [CW-1:0] B2,
  input  logic signed [CW-1:0] C2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_tile_x,
  output logic [15:0]          out_tile_y,
  output logic                 out_full,
  output logic                 tri_done,
  output logic [15:0]          tile_count
);

  localparam int SH = FW + TILE_LOG2;

  typedef enum logic [1:0] {IDLE, SETUP, WALK} state_t;
  state_t state, state_nxt;

  logic [15:0]          x_min_q, x_max_q, y_min_q, y_max_q, cx, cy;
  logic signed [CW-1:0] a_q [3];
  logic signed [CW-1:0] b_q [3];
  logic signed [CW-1:0] c_q [3];
  logic signed [EW-1:0] e_q [3];
  logic signed [EW-1:0] erow_q [3];
  logic signed [EW-1:0] sx [3];
  logic signed [EW-1:0] sy [3];
  logic signed [EW-1:0] e10 [3];
  logic signed [EW-1:0] e01 [3];
  logic signed [EW-1:0] e11 [3];
  logic signed [EW-1:0] erow_init [3];
  logic signed [EW-1:0] x0, y0;
  logic [2:0] edge_out, edge_in;
  logic accept_in, bbox_empty, reject, full, advance, slot_free, row_end, last_tile;

  assign in_ready   = (state == IDLE);
  assign accept_in  = in_valid && in_ready;
  assign bbox_empty = (tile_x_min > tile_x_max) || (tile_y_min > tile_y_max);
  assign slot_free  = !out_valid || out_ready;
  assign row_end    = (cx >= x_max_q);
  assign last_tile  = row_end && (cy >= y_max_q);
  assign x0         = EW'({x_min_q, {SH{1'b0}}});
  assign y0         = EW'({y_min_q, {SH{1'b0}}});

  // Corner i is outside an edge exactly when its EW-bit value is negative.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sx[i]        = EW'(a_q[i]) <<< SH;
      sy[i]        = EW'(b_q[i]) <<< SH;
      e10[i]       = e_q[i] + sx[i];
      e01[i]       = e_q[i] + sy[i];
      e11[i]       = e_q[i] + sx[i] + sy[i];
      edge_out[i]  = e_q[i][EW-1] & e10[i][EW-1] & e01[i][EW-1] & e11[i][EW-1];
      edge_in[i]   = ~(e_q[i][EW-1] | e10[i][EW-1] | e01[i][EW-1] | e11[i][EW-1]);
      erow_init[i] = EW'(a_q[i]) * x0 + EW'(b_q[i]) * y0 + EW'(c_q[i]);
    end
    reject = |edge_out;
    full   = &edge_in;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    unique case (state)
      IDLE:  if (in_valid) state_nxt = bbox_empty ? IDLE : SETUP;
      SETUP: state_nxt = WALK;
      WALK: begin
        advance = reject || slot_free;
        if (advance && last_tile) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: working registers carry no reset; the FSM never consumes them before a descriptor loads them.
  always_ff @(posedge clk) begin
    if (accept_in) begin
      x_min_q <= tile_x_min;
      x_max_q <= tile_x_max;
      y_min_q <= tile_y_min;
      y_max_q <= tile_y_max;
      a_q[0] <= A0; b_q[0] <= B0; c_q[0] <= C0;
      a_q[1] <= A1; b_q[1] <= B1; c_q[1] <= C1;
      a_q[2] <= A2; b_q[2] <= B2; c_q[2] <= C2;
    end
    if (state == SETUP) begin
      cx <= x_min_q;
      cy <= y_min_q;
      for (int i = 0; i < 3; i++) begin
        e_q[i]    <= erow_init[i];
        erow_q[i] <= erow_init[i];
      end
    end else if (advance) begin
      if (!row_end) begin
        cx <= cx + 16'd1;
        for (int i = 0; i < 3; i++) e_q[i] <= e_q[i] + sx[i];
      end else begin
        cx <= x_min_q;
        cy <= cy + 16'd1;
        for (int i = 0; i < 3; i++) begin
          erow_q[i] <= erow_q[i] + sy[i];
          e_q[i]    <= erow_q[i] + sy[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_tile_x <= '0;
      out_tile_y <= '0;
      out_full   <= 1'b0;
      tri_done   <= 1'b0;
      tile_count <= '0;
    end else begin
      tri_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept_in) begin
        tile_count <= '0;
        if (bbox_empty) tri_done <= 1'b1;
      end
      if (advance) begin
        if (!reject) begin
          out_valid  <= 1'b1;
          out_tile_x <= cx;
          out_tile_y <= cy;
          out_full   <= full;
          if (tile_count != 16'hFFFF) tile_count <= tile_count + 16'd1;
        end
        if (last_tile) tri_done <= 1'b1;
      end
    end
  end

endmodule
